fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the instruction decoder. Holds the PC, issues word requests to instruction memory over a valid/ready handshake, buffers in-order responses in a small FIFO, and presents one 32-bit instruction plus its PC per cycle to decode. Branch/BX redirects from execute flush the buffer and discard stale in-flight responses.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_buffer.sv | 62 ++++++
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
package fetch_pkg;

    localparam int WORD_BYTES = 4;
    localparam int INSTR_W    = 32;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'(WORD_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small registered FIFO with zero-cycle head visibility and a synchronous flush.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_entry_t
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  T                      push_data,
    input  logic                  pop,
    output T                      head,
    output logic                  full,
    output logic                  empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    T              mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // A pop frees the slot this cycle, so push while full is legal alongside it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign empty   = (count == '0);
    assign full    = (count == (AW + 1)'(DEPTH));
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    push_into_full: assert property (@(posedge clk) disable iff (rst)
        !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, request issue, in-order response buffering, redirect drain.
// Optional macro FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  pc;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] drop_next;
    logic [CW-1:0] inflight_after;
    logic [CW-1:0] buf_count;
    logic [CW-1:0] aq_count;
    logic [CW:0]   occupancy;
    logic          buf_full;
    logic          buf_empty;
    logic          aq_full;
    logic          aq_empty;
    logic          unused_flags;
    fetch_entry_t  buf_head;
    fetch_entry_t  rsp_entry;
    logic [31:0]   aq_head;
    logic          accept;
    logic          rsp_live;
    logic          rsp_take;
    logic          pop;

    // Handshakes: a beat transfers only in a cycle where valid and ready are both high.
    assign accept   = imem_req_valid && imem_req_ready;
    assign rsp_live = imem_rsp_valid && !aq_empty;
    assign rsp_take = (state == RUN) && rsp_live && !redirect_valid;
    assign pop      = instr_valid && instr_ready && !redirect_valid;

    // A slot freed by this cycle's pop may be requested again immediately.
    assign occupancy      = {1'b0, aq_count} + {1'b0, buf_count} - (CW + 1)'(pop);
    assign inflight_after = aq_count + CW'(accept) - CW'(rsp_live);
    assign unused_flags   = buf_full ^ aq_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BOOT;
            drop_cnt <= '0;
        end else begin
            state    <= state_next;
            drop_cnt <= drop_next;
        end
    end

    always_comb begin
        state_next = state;
        drop_next  = drop_cnt;
        unique case (state)
            BOOT: state_next = RUN;
            RUN: begin
                if (redirect_valid && (inflight_after != '0)) begin
                    state_next = DRAIN;
                    drop_next  = inflight_after;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid) begin
                    drop_next = drop_cnt - 1'b1;
                    if (drop_cnt == CW'(1)) begin
                        state_next = RUN;
                    end
                end
            end
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        imem_req_valid = 1'b0;
        if ((state == RUN) && !redirect_valid && (occupancy < (CW + 1)'(BUF_DEPTH))) begin
            imem_req_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= align_word(RESET_PC);
        end else if (redirect_valid) begin
            pc <= align_word(redirect_pc);
        end else if (accept) begin
            pc <= pc + 32'(WORD_BYTES);
        end
    end

    assign imem_addr = pc;
    assign rsp_entry = '{instr: imem_rsp_data, pc: aq_head};

    fetch_buffer #(.DEPTH(BUF_DEPTH), .T(logic [31:0])) u_addr_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (accept),
        .push_data (pc),
        .pop       (rsp_take),
        .head      (aq_head),
        .full      (aq_full),
        .empty     (aq_empty),
        .count     (aq_count)
    );

    fetch_buffer #(.DEPTH(BUF_DEPTH), .T(fetch_entry_t)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (rsp_take),
        .push_data (rsp_entry),
        .pop       (pop),
        .head      (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    assign instr_valid = !buf_empty;
    assign instr       = instr_valid ? buf_head.instr : '0;
    assign instr_pc    = instr_valid ? buf_head.pc : '0;

`ifdef FETCH_PERF_EN
    // Flushed counts everything fetched-but-unconsumed when a redirect lands in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(pop);
            if (redirect_valid) begin
                perf_flushed <= perf_flushed + 32'(buf_count)
                              + ((state == RUN) ? (32'(aq_count) + 32'(accept)) : 32'd0);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with an in-order memory model and a PC scoreboard.
`timescale 1ns/1ps
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          BUF_DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests;
    int          n_fail;
    logic [31:0] exp_q[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] acc_q[$];
    logic [31:0] pop_pc_q[$];
    int          cyc;
    int          lat;
    int          pop_count;
    int          first_valid_cyc;
    int          first_acc_cyc;
    logic [31:0] exp_pc;
    logic [31:0] fetched_exp;
    logic [31:0] flushed_exp;
    bit          rand_mode;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_trackers();
        acc_q.delete();
        pop_pc_q.delete();
        pop_count       = 0;
        first_valid_cyc = -1;
        first_acc_cyc   = -1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        exp_q.delete();
        #1;
        check_eq("rst_req_valid", imem_req_valid, 1'b0);
        check_eq("rst_imem_addr", imem_addr, RESET_PC);
        check_eq("rst_instr_valid", instr_valid, 1'b0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_instr_pc", instr_pc, 32'h0);
        check_eq("rst_state", dut.state, BOOT);
`ifdef FETCH_PERF_EN
        check_eq("rst_perf_fetched", perf_fetched, 32'h0);
        check_eq("rst_perf_flushed", perf_flushed, 32'h0);
`endif
        fetched_exp = '0;
        flushed_exp = '0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        cyc    = 0;
        exp_pc = RESET_PC;
        clear_trackers();
    endtask

    // One clock cycle: drive at edge+1, sample at the falling edge.
    task automatic step(input logic rv, input logic [31:0] rpc);
        logic [31:0] e;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (rand_mode) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            instr_ready    = ($urandom_range(0, 2) != 0);
        end
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #4;
        if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (!rv && instr_valid && instr_ready) begin
            check_eq("sb_nonempty", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("instr_pc", instr_pc, e);
                check_eq("instr", instr, mem_word(e));
                pop_pc_q.push_back(instr_pc);
                pop_count++;
                fetched_exp++;
            end
        end
        if (rv) begin
            check_eq("no_req_on_redirect", imem_req_valid, 1'b0);
            flushed_exp += exp_q.size();
            exp_q.delete();
            exp_pc = rpc & ~32'h3;
        end
        if (imem_req_valid && imem_req_ready) begin
            pend_addr.push_back(imem_addr);
            pend_due.push_back(cyc + lat);
            if (!rv) begin
                check_eq("imem_addr", imem_addr, exp_pc);
                exp_q.push_back(exp_pc);
                acc_q.push_back(imem_addr);
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                exp_pc += 32'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid = 1'b0;
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rand_mode      = 1'b0;
        lat            = 1;
        rst            = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        fetched_exp    = '0;
        flushed_exp    = '0;
        cyc            = 0;
        clear_trackers();
        #2;
        do_reset();

        // Streaming, 1-cycle latency
        for (int i = 0; i < 13; i++) step(1'b0, 32'h0);
        check_eq("first_valid_cyc", first_valid_cyc, 3);
        check_eq("steady_pops", pop_count, 10);
        check_eq("acc_addr1", (acc_q.size() > 1) ? acc_q[1] : 32'hFFFF_FFFF, 32'h4);

        // Decode stall fills the buffer
        do_reset();
        instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0);
        check_eq("stall_no_req", imem_req_valid, 1'b0);
        check_eq("stall_valid", instr_valid, 1'b1);
        check_eq("stall_buffered", exp_q.size(), BUF_DEPTH);
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0);
        check_eq("stall_pops", pop_pc_q.size() >= 2, 1'b1);
        if (pop_pc_q.size() >= 2) begin
            check_eq("stall_pop0", pop_pc_q[0], 32'h0);
            check_eq("stall_pop1", pop_pc_q[1], 32'h4);
        end

        // Redirect with two requests in flight, 3-cycle latency
        do_reset();
        lat = 3;
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0);
        clear_trackers();
        step(1'b1, 32'h100);
        check_eq("drain_state", dut.state, DRAIN);
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0);
        check_eq("drain_first_req_cyc", first_acc_cyc, 6);
        check_eq("drain_first_pop", (pop_pc_q.size() > 0) ? pop_pc_q[0] : 32'hFFFF_FFFF, 32'h100);

        // Redirect coinciding with an arriving response
        do_reset();
        lat = 1;
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0);
        clear_trackers();
        step(1'b1, 32'h200);
        check_eq("coincide_state", dut.state, RUN);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0);
        check_eq("coincide_req_cyc", first_acc_cyc, 7);
        check_eq("coincide_first_pop", (pop_pc_q.size() > 0) ? pop_pc_q[0] : 32'hFFFF_FFFF, 32'h200);

        // Address wrap and target alignment
        clear_trackers();
        step(1'b1, 32'hFFFF_FFFC);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0);
        check_eq("wrap_addr0", (acc_q.size() > 0) ? acc_q[0] : 32'h1, 32'hFFFF_FFFC);
        check_eq("wrap_addr1", (acc_q.size() > 1) ? acc_q[1] : 32'h1, 32'h0);
        clear_trackers();
        step(1'b1, 32'h103);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0);
        check_eq("align_addr", (acc_q.size() > 0) ? acc_q[0] : 32'h1, 32'h100);

        // Reset in the middle of DRAIN
        do_reset();
        lat = 3;
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0);
        step(1'b1, 32'h40);
        check_eq("pre_rst_state", dut.state, DRAIN);
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0);
        check_eq("post_rst_addr", (acc_q.size() > 0) ? acc_q[0] : 32'h1, RESET_PC);
        check_eq("post_rst_pop", (pop_pc_q.size() > 0) ? pop_pc_q[0] : 32'h1, RESET_PC);

        // Random backpressure and redirects
        lat       = 2;
        rand_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 15) == 0, $urandom);
        end
        rand_mode      = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0);
`ifdef FETCH_PERF_EN
        check_eq("perf_fetched", perf_fetched, fetched_exp);
        check_eq("perf_flushed", perf_flushed, flushed_exp);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
